// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared definitions for the 8-way round-robin arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of a requester index
//   arb_state_t : arbiter FSM state (IDLE / GRANT / RELEASE), 2-bit encoding
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8 -- combinational round-robin winner search.
// Rotates req so that bit (ptr+1) mod 8 lands at position 0, priority-encodes
// the lowest set bit, then rotates the position back into a requester index.
// Ports:
//   req [7:0] in  : request vector
//   ptr [2:0] in  : index of the previous winner
//   idx [2:0] out : winning requester (0 when any is low)
//   any       out : at least one request is set
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [ID_W-1:0]  start;
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  pos;

    assign start = ptr + ID_W'(1);

    // rot[k] holds req[(start + k) mod 8]; the 3-bit add wraps naturally.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            localparam logic [ID_W-1:0] OFF = ID_W'(gi);
            assign rot[gi] = req[OFF + start];
        end
    endgenerate

    // Scan from the top down so the lowest set rotated bit is the last write.
    always_comb begin
        pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = ID_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = any ? (pos + start) : '0;

endmodule

// File: rtl/rr_arb8.sv
// rr_arb8 -- 8-requester round-robin arbiter with registered one-hot grant.
// A grant is held while the winner keeps its request high; dropping it costs
// one RELEASE cycle before the next arbitration from IDLE.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX
// GRANT cycles, signalled by a one-cycle tmo pulse.
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : synchronous reset, active-high
//   req    [7:0] in  : request per requester
//   gnt    [7:0] out : one-hot grant (registered)
//   gnt_id [2:0] out : binary index of the granted requester (registered)
//   gnt_vld      out : a grant is active
//   tmo          out : grant revoked by timeout (one-cycle pulse)
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld,
    output logic             tmo
);

    generate
        if (HOLD_MAX < 1) begin : g_hold_check
            $error("rr_arb8: HOLD_MAX must be at least 1");
        end
    endgenerate

    arb_state_t       state_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [ID_W-1:0]  gnt_id_reg;
    logic             gnt_vld_reg;
    // Low for the first edge after reset so req is not arbitrated until the
    // second edge with rst low.
    logic             arm_reg;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] onehot_next;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign onehot_next[gi] = (pick_idx == ID_W'(gi));
        end
    endgenerate

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX) + 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             tmo_reg;
    logic             hold_expired;

    assign hold_expired = (cnt_reg == CNT_W'(HOLD_MAX - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= ID_W'(N_REQ - 1);
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            gnt_vld_reg <= 1'b0;
            arm_reg     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg     <= '0;
            tmo_reg     <= 1'b0;
`endif
        end else begin
            arm_reg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            tmo_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (arm_reg && pick_any) begin
                        state_reg   <= GRANT;
                        gnt_reg     <= onehot_next;
                        gnt_id_reg  <= pick_idx;
                        gnt_vld_reg <= 1'b1;
                        ptr_reg     <= pick_idx;
`ifdef ARB_TIMEOUT_EN
                        cnt_reg     <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A voluntary release wins over a coincident timeout.
                    if (!req[gnt_id_reg]) begin
                        state_reg   <= RELEASE;
                        gnt_reg     <= '0;
                        gnt_id_reg  <= '0;
                        gnt_vld_reg <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_expired) begin
                        state_reg   <= RELEASE;
                        gnt_reg     <= '0;
                        gnt_id_reg  <= '0;
                        gnt_vld_reg <= 1'b0;
                        tmo_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    gnt_reg     <= '0;
                    gnt_id_reg  <= '0;
                    gnt_vld_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign gnt_vld = gnt_vld_reg;

`ifdef ARB_TIMEOUT_EN
    assign tmo = tmo_reg;
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8 -- directed checks of rr_arb8 plus a random property run.
// Observed outputs are packed as {gnt, gnt_id, gnt_vld, tmo}.
module tb_rr_arb8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       tmo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] obs;
    logic [12:0] exp;
    assign obs = {gnt, gnt_id, gnt_vld, tmo};

    rr_arb8 #(.HOLD_MAX(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = 13'h0;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_cyc%0d obs=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_single();
        rst = 1'b0;
        req = 8'h01;
        tick();
        exp = 13'h0;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL single_first_edge obs=%h exp=%h", obs, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {8'h01, 3'd0, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_grant_cyc%0d obs=%h exp=%h", i, obs, exp);
            end
        end
        req = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = 13'h0;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_release_cyc%0d obs=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] id;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            id = 3'(i % 8);
            tick();
            exp = {8'(1 << id), id, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rr_grant%0d obs=%h exp=%h", i, obs, exp);
            end
            tick();
            tick();
            req = 8'hFF & ~8'(1 << id);
            tick();
            req = 8'hFF;
            tick();
            exp = 13'h0;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rr_gap%0d obs=%h exp=%h", i, obs, exp);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_hold_and_wrap();
        req = 8'h20;
        tick();
        exp = {8'h20, 3'd5, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL wrap_setup obs=%h exp=%h", obs, exp);
        end
        req = 8'h27;
        tick();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL hold_other_req obs=%h exp=%h", obs, exp);
        end
        req = 8'hFF;
        tick();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL hold_all_req obs=%h exp=%h", obs, exp);
        end
        req = 8'h00;
        tick();
        tick();
        req = 8'h21;
        tick();
        exp = {8'h01, 3'd0, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL wrap_to_0 obs=%h exp=%h", obs, exp);
        end
        req = 8'h00;
        tick();
        tick();
        req = 8'h21;
        tick();
        exp = {8'h20, 3'd5, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL wrap_then_5 obs=%h exp=%h", obs, exp);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rst_during_grant();
        req = 8'h08;
        tick();
        exp = {8'h08, 3'd3, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rstg_grant3 obs=%h exp=%h", obs, exp);
        end
        rst = 1'b1;
        tick();
        exp = 13'h0;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rstg_drop obs=%h exp=%h", obs, exp);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rstg_edge1 obs=%h exp=%h", obs, exp);
        end
        tick();
        exp = {8'h08, 3'd3, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rstg_edge2 obs=%h exp=%h", obs, exp);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 8'h04;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = {8'h04, 3'd2, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL tmo_hold_cyc%0d obs=%h exp=%h", i, obs, exp);
            end
        end
        tick();
        exp = {8'h00, 3'd0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_pulse obs=%h exp=%h", obs, exp);
        end
        tick();
        exp = 13'h0;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_idle obs=%h exp=%h", obs, exp);
        end
        tick();
        exp = {8'h04, 3'd2, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_regrant obs=%h exp=%h", obs, exp);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_last_cycle obs=%h exp=%h", obs, exp);
        end
        req = 8'h00;
        tick();
        exp = 13'h0;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_release_wins obs=%h exp=%h", obs, exp);
        end
        tick();
    endtask
`else
    task automatic test_hold_forever();
        req = 8'h04;
        for (int i = 0; i < 41; i++) begin
            tick();
            exp = {8'h04, 3'd2, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL hold_forever_cyc%0d obs=%h exp=%h", i, obs, exp);
            end
        end
        req = 8'h00;
        tick();
        tick();
    endtask
`endif

    task automatic test_random();
        logic prev_vld;
        logic in_release;
        logic ok;
        int   shown;
        prev_vld   = 1'b0;
        in_release = 1'b0;
        shown      = 0;
        for (int i = 0; i < 10000; i++) begin
            req = 8'($urandom_range(0, 255));
            tick();
            ok = $onehot0(gnt) && (gnt_vld == (|gnt)) && (gnt_vld || gnt_id == 3'd0);
            if (in_release && gnt_vld) begin
                ok = 1'b0;
            end
            n_cmp++;
            if (!ok) begin
                n_bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cyc%0d gnt=%h id=%0d vld=%b after_release=%b",
                             i, gnt, gnt_id, gnt_vld, in_release);
                end
            end
            in_release = prev_vld && !gnt_vld;
            prev_vld   = gnt_vld;
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_and_wrap();
        test_rst_during_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
